// File: rtl/cpu_params_pkg.sv
// -----------------------------------------------------------------------------
// cpu_params_pkg
//   Shared CPU constants used by the CSR write scheduler:
//     - CPU_RSZ                 default register / CSR data width
//     - CSR_*_ADDR              machine-mode trap CSR addresses
//     - MIE_BIT/MPIE_BIT/MPP_LO mstatus field positions
// -----------------------------------------------------------------------------
package cpu_params_pkg;

   localparam int unsigned CPU_RSZ = 32;

   localparam logic [11:0] CSR_MSTATUS_ADDR = 12'h300;
   localparam logic [11:0] CSR_MEPC_ADDR    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE_ADDR  = 12'h342;
   localparam logic [11:0] CSR_MTVAL_ADDR   = 12'h343;

   localparam int MIE_BIT  = 3;
   localparam int MPIE_BIT = 7;
   localparam int MPP_LO   = 11;

endpackage

// File: rtl/cpu_structs_pkg.sv
// -----------------------------------------------------------------------------
// cpu_structs_pkg
//   Types shared by the CSR write scheduler:
//     - csr_sched_state_t  scheduler state; each state names the write that is
//                          on the CSR port in that cycle
//     - trap_cap_t         trap payload captured at trap acceptance
//   Optional feature macro: CSR_TVAL_WR_EN (adds the T_TVAL state and the
//   captured tval field).
// -----------------------------------------------------------------------------
package cpu_structs_pkg;
   import cpu_params_pkg::*;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SW       = 3'd1,
      T_EPC    = 3'd2,
      T_CAUSE  = 3'd3,
`ifdef CSR_TVAL_WR_EN
      T_TVAL   = 3'd4,
`endif
      T_STATUS = 3'd5,
      M_STATUS = 3'd6
   } csr_sched_state_t;

   typedef struct packed {
      logic [CPU_RSZ-1:0] epc;
      logic [CPU_RSZ-1:0] cause;
`ifdef CSR_TVAL_WR_EN
      logic [CPU_RSZ-1:0] tval;
`endif
      logic [1:0]         mode;
   } trap_cap_t;

endpackage

// File: rtl/mstatus_upd.sv
// -----------------------------------------------------------------------------
// mstatus_upd
//   Combinational new-mstatus calculator for trap entry and MRET.
//   Ports:
//     mstatus       in   RSZ  current mstatus contents
//     trap_mode     in   2    privilege mode captured at trap acceptance
//     trap_mstatus  out  RSZ  MPIE<=MIE, MIE<=0, MPP<=trap_mode
//     mret_mstatus  out  RSZ  MIE<=MPIE, MPIE<=1, MPP<=0
//   All other bits pass through unchanged.
// -----------------------------------------------------------------------------
module mstatus_upd
   import cpu_params_pkg::*;
#(
   parameter int unsigned RSZ = CPU_RSZ
) (
   input  logic [RSZ-1:0] mstatus,
   input  logic [1:0]     trap_mode,
   output logic [RSZ-1:0] trap_mstatus,
   output logic [RSZ-1:0] mret_mstatus
);

   always_comb begin
      trap_mstatus                = mstatus;
      trap_mstatus[MPIE_BIT]      = mstatus[MIE_BIT];
      trap_mstatus[MIE_BIT]       = 1'b0;
      trap_mstatus[MPP_LO +: 2]   = trap_mode;

      mret_mstatus                = mstatus;
      mret_mstatus[MIE_BIT]       = mstatus[MPIE_BIT];
      mret_mstatus[MPIE_BIT]      = 1'b1;
      mret_mstatus[MPP_LO +: 2]   = 2'b00;
   end

endmodule

// File: rtl/csr_wr_sched.sv
// -----------------------------------------------------------------------------
// csr_wr_sched
//   Owner of the single CSR write port, shared between software CSR writes
//   (WB stage), the trap-entry sequence and MRET. Trap entry is issued as
//   back-to-back writes (mepc, mcause, [mtval], mstatus) and busy stalls the
//   pipeline while a trap or MRET is in flight.
//
//   Optional feature macro: CSR_TVAL_WR_EN
//     defined   : trap writes mepc, mcause, mtval, mstatus (4 writes)
//     undefined : trap writes mepc, mcause, mstatus (3 writes); trap_tval is
//                 accepted on the port but ignored
//
//   Ports:
//     clk_in, reset_in          clock, synchronous active-high reset
//     sw_valid/sw_addr/sw_data  software write request; sw_ready = accepted
//     trap_req/trap_epc/trap_cause/trap_tval/cur_mode
//                               trap request; trap_ack = accepted
//     mret_req                  MRET request; mret_ack = accepted
//     mstatus_in                live mstatus contents
//     csr_wr/csr_wr_addr/csr_wr_data  CSR write port (Moore-decoded)
//     busy                      trap/MRET in flight (pipeline stall)
//     trap_done, mret_done      pulse on final trap write / MRET write
//     mret_mode                 old MPP sampled at MRET acceptance
//     state_dbg                 current scheduler state, for observation
// -----------------------------------------------------------------------------
module csr_wr_sched
   import cpu_params_pkg::*;
   import cpu_structs_pkg::*;
#(
   parameter int unsigned RSZ          = CPU_RSZ,
   parameter logic [11:0] MSTATUS_ADDR = CSR_MSTATUS_ADDR,
   parameter logic [11:0] MEPC_ADDR    = CSR_MEPC_ADDR,
   parameter logic [11:0] MCAUSE_ADDR  = CSR_MCAUSE_ADDR,
   parameter logic [11:0] MTVAL_ADDR   = CSR_MTVAL_ADDR
) (
   input  logic             clk_in,
   input  logic             reset_in,

   input  logic             sw_valid,
   input  logic [11:0]      sw_addr,
   input  logic [RSZ-1:0]   sw_data,
   output logic             sw_ready,

   input  logic             trap_req,
   input  logic [RSZ-1:0]   trap_epc,
   input  logic [RSZ-1:0]   trap_cause,
   input  logic [RSZ-1:0]   trap_tval,
   input  logic [1:0]       cur_mode,
   output logic             trap_ack,

   input  logic             mret_req,
   output logic             mret_ack,

   input  logic [RSZ-1:0]   mstatus_in,

   output logic             csr_wr,
   output logic [11:0]      csr_wr_addr,
   output logic [RSZ-1:0]   csr_wr_data,

   output logic             busy,
   output logic             trap_done,
   output logic             mret_done,
   output logic [1:0]       mret_mode,

   output csr_sched_state_t state_dbg
);

   csr_sched_state_t state, state_nxt;

   trap_cap_t        cap_q;
   logic [11:0]      sw_addr_q;
   logic [RSZ-1:0]   sw_data_q;
   logic [1:0]       mret_mode_q;

   logic             accept_win;
   logic [RSZ-1:0]   trap_mstatus;
   logic [RSZ-1:0]   mret_mstatus;

`ifndef CSR_TVAL_WR_EN
   // trap_tval stays on the port for interface stability but carries no use.
   logic             tval_unused;
   assign tval_unused = ^trap_tval;
`endif

   // ---------------------------------------------------------------------------
   // Handshake: each requester presents its request flag with payload; a
   // transfer happens in the cycle its ack/ready is high, and the payload is
   // captured at the following clock edge. Acks are combinational and only
   // asserted in the accept window (a state whose write is the last of its
   // transaction), with priority trap > mret > sw. A software write that loses
   // to a trap is dropped, since upstream flushes that instruction.
   // ---------------------------------------------------------------------------
   assign accept_win = (state == IDLE)     || (state == SW) ||
                       (state == T_STATUS) || (state == M_STATUS);

   assign trap_ack = accept_win & trap_req;
   assign mret_ack = accept_win & mret_req & ~trap_req;
   assign sw_ready = accept_win & sw_valid & ~trap_req & ~mret_req;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         T_EPC:   state_nxt = T_CAUSE;
`ifdef CSR_TVAL_WR_EN
         T_CAUSE: state_nxt = T_TVAL;
         T_TVAL:  state_nxt = T_STATUS;
`else
         T_CAUSE: state_nxt = T_STATUS;
`endif
         default: begin
            // Accept window: a new request starts writing the very next cycle.
            if (trap_ack) begin
               state_nxt = T_EPC;
            end else if (mret_ack) begin
               state_nxt = M_STATUS;
            end else if (sw_ready) begin
               state_nxt = SW;
            end else begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Payload capture
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         cap_q       <= '0;
         sw_addr_q   <= '0;
         sw_data_q   <= '0;
         mret_mode_q <= 2'b00;
      end else begin
         if (trap_ack) begin
            cap_q.epc   <= trap_epc;
            cap_q.cause <= trap_cause;
`ifdef CSR_TVAL_WR_EN
            cap_q.tval  <= trap_tval;
`endif
            cap_q.mode  <= cur_mode;
         end
         if (sw_ready) begin
            sw_addr_q <= sw_addr;
            sw_data_q <= sw_data;
         end
         if (mret_ack) begin
            mret_mode_q <= mstatus_in[MPP_LO +: 2];
         end
      end
   end

   // mstatus values are computed from the live mstatus_in in the cycle the
   // write is issued, so any earlier CSR write has already landed.
   mstatus_upd #(
      .RSZ (RSZ)
   ) u_mstatus_upd (
      .mstatus      (mstatus_in),
      .trap_mode    (cap_q.mode),
      .trap_mstatus (trap_mstatus),
      .mret_mstatus (mret_mstatus)
   );

   // ---------------------------------------------------------------------------
   // Moore output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      csr_wr      = 1'b0;
      csr_wr_addr = '0;
      csr_wr_data = '0;
      busy        = 1'b0;
      trap_done   = 1'b0;
      mret_done   = 1'b0;
      case (state)
         SW: begin
            csr_wr      = 1'b1;
            csr_wr_addr = sw_addr_q;
            csr_wr_data = sw_data_q;
         end
         T_EPC: begin
            csr_wr         = 1'b1;
            busy           = 1'b1;
            csr_wr_addr    = MEPC_ADDR;
            csr_wr_data    = cap_q.epc;
            csr_wr_data[0] = 1'b0;
         end
         T_CAUSE: begin
            csr_wr      = 1'b1;
            busy        = 1'b1;
            csr_wr_addr = MCAUSE_ADDR;
            csr_wr_data = cap_q.cause;
         end
`ifdef CSR_TVAL_WR_EN
         T_TVAL: begin
            csr_wr      = 1'b1;
            busy        = 1'b1;
            csr_wr_addr = MTVAL_ADDR;
            csr_wr_data = cap_q.tval;
         end
`endif
         T_STATUS: begin
            csr_wr      = 1'b1;
            busy        = 1'b1;
            trap_done   = 1'b1;
            csr_wr_addr = MSTATUS_ADDR;
            csr_wr_data = trap_mstatus;
         end
         M_STATUS: begin
            csr_wr      = 1'b1;
            busy        = 1'b1;
            mret_done   = 1'b1;
            csr_wr_addr = MSTATUS_ADDR;
            csr_wr_data = mret_mstatus;
         end
         default: begin
            csr_wr = 1'b0;
         end
      endcase
   end

   assign mret_mode = mret_mode_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_csr_wr_sched.sv
// -----------------------------------------------------------------------------
// tb_csr_wr_sched
//   Directed vector table, hand-written reset-abort sequence and a randomized
//   run against a transaction-level model of the CSR write port.
// -----------------------------------------------------------------------------
module tb_csr_wr_sched;
   import cpu_structs_pkg::*;

`ifdef CSR_TVAL_WR_EN
   localparam bit TVAL_EN = 1'b1;
`else
   localparam bit TVAL_EN = 1'b0;
`endif

   // ---------------------------------------------------------------- signals
   logic             clk_in   = 1'b0;
   logic             reset_in = 1'b1;
   logic             sw_valid = 1'b0;
   logic [11:0]      sw_addr  = '0;
   logic [31:0]      sw_data  = '0;
   logic             sw_ready;
   logic             trap_req = 1'b0;
   logic [31:0]      trap_epc = '0;
   logic [31:0]      trap_cause = '0;
   logic [31:0]      trap_tval = '0;
   logic [1:0]       cur_mode = '0;
   logic             trap_ack;
   logic             mret_req = 1'b0;
   logic             mret_ack;
   logic [31:0]      mstatus_in = '0;
   logic             csr_wr;
   logic [11:0]      csr_wr_addr;
   logic [31:0]      csr_wr_data;
   logic             busy;
   logic             trap_done;
   logic             mret_done;
   logic [1:0]       mret_mode;
   csr_sched_state_t state_dbg;

   int total = 0;
   int bad   = 0;

   csr_wr_sched dut (
      .clk_in      (clk_in),
      .reset_in    (reset_in),
      .sw_valid    (sw_valid),
      .sw_addr     (sw_addr),
      .sw_data     (sw_data),
      .sw_ready    (sw_ready),
      .trap_req    (trap_req),
      .trap_epc    (trap_epc),
      .trap_cause  (trap_cause),
      .trap_tval   (trap_tval),
      .cur_mode    (cur_mode),
      .trap_ack    (trap_ack),
      .mret_req    (mret_req),
      .mret_ack    (mret_ack),
      .mstatus_in  (mstatus_in),
      .csr_wr      (csr_wr),
      .csr_wr_addr (csr_wr_addr),
      .csr_wr_data (csr_wr_data),
      .busy        (busy),
      .trap_done   (trap_done),
      .mret_done   (mret_done),
      .mret_mode   (mret_mode),
      .state_dbg   (state_dbg)
   );

   // -------------------------------------------------------- clock / reset
   always #5 clk_in = ~clk_in;

   // ------------------------------------------------------------ vector table
   // flags = {busy, trap_done, mret_done, trap_ack, mret_ack, sw_ready}
   typedef struct {
      logic        rst;
      logic        swv;
      logic [11:0] swa;
      logic [31:0] swd;
      logic        trq;
      logic [31:0] epc;
      logic [31:0] cause;
      logic [31:0] tval;
      logic [1:0]  mode;
      logic        mrq;
      logic [31:0] mst;
      logic        e_wr;
      logic [11:0] e_addr;
      logic [31:0] e_data;
      logic [5:0]  e_flags;
      logic [1:0]  e_mmode;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic swv, input logic [11:0] swa,
                      input logic [31:0] swd, input logic trq, input logic [31:0] epc,
                      input logic [31:0] cause, input logic [31:0] tval,
                      input logic [1:0] mode, input logic mrq, input logic [31:0] mst,
                      input logic e_wr, input logic [11:0] e_addr,
                      input logic [31:0] e_data, input logic [5:0] e_flags,
                      input logic [1:0] e_mmode);
      vec_t v;
      v.rst = rst; v.swv = swv; v.swa = swa; v.swd = swd;
      v.trq = trq; v.epc = epc; v.cause = cause; v.tval = tval; v.mode = mode;
      v.mrq = mrq; v.mst = mst;
      v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
      v.e_flags = e_flags; v.e_mmode = e_mmode;
      tbl.push_back(v);
   endtask

   // ------------------------------------------------------------ driver tasks
   task automatic drive(input logic rst, input logic swv, input logic [11:0] swa,
                        input logic [31:0] swd, input logic trq, input logic [31:0] epc,
                        input logic [31:0] cause, input logic [31:0] tval,
                        input logic [1:0] mode, input logic mrq, input logic [31:0] mst);
      reset_in   = rst;
      sw_valid   = swv;
      sw_addr    = swa;
      sw_data    = swd;
      trap_req   = trq;
      trap_epc   = epc;
      trap_cause = cause;
      trap_tval  = tval;
      cur_mode   = mode;
      mret_req   = mrq;
      mstatus_in = mst;
   endtask

   task automatic idle(input logic [31:0] mst);
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 2'b00, 1'b0, mst);
   endtask

   // ------------------------------------------------------------- checking
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_wr, input logic [11:0] e_addr,
                          input logic [31:0] e_data, input logic [5:0] e_flags,
                          input logic [1:0] e_mmode);
      chk({tag, " csr_wr"}, 32'(csr_wr), 32'(e_wr));
      if (e_wr) begin
         chk({tag, " csr_wr_addr"}, 32'(csr_wr_addr), 32'(e_addr));
         chk({tag, " csr_wr_data"}, csr_wr_data, e_data);
      end
      chk({tag, " flags{busy,tdone,mdone,tack,mack,swr}"},
          32'({busy, trap_done, mret_done, trap_ack, mret_ack, sw_ready}), 32'(e_flags));
      chk({tag, " mret_mode"}, 32'(mret_mode), 32'(e_mmode));
   endtask

   // -------------------------------------------------------- scoreboard model
   // The port is modelled as a queue of pending writes; the head is the write
   // on the port this cycle. A new request may be taken only when nothing is
   // queued behind the current write. Entry: {kind, mode, addr, data} where
   // kind 0 = software, 1 = trap register, 2 = trap mstatus, 3 = MRET mstatus.
   // mstatus entries get their data from the live mstatus_in when issued.
   logic [47:0] exp_q[$];
   logic [1:0]  m_mmode;

   task automatic model_cycle(input string tag);
      logic        has;
      logic [47:0] head;
      logic [1:0]  kind;
      logic [1:0]  hmode;
      logic [31:0] ed;
      logic        win, tack, mack, swr;
      has   = (exp_q.size() > 0);
      head  = has ? exp_q[0] : 48'h0;
      kind  = head[47:46];
      hmode = head[45:44];
      ed    = head[31:0];
      if (has && kind == 2'd2)
         ed = (mstatus_in & ~32'h0000_1888) | (32'(mstatus_in[3]) << 7) | (32'(hmode) << 11);
      else if (has && kind == 2'd3)
         ed = (mstatus_in & ~32'h0000_1888) | (32'(mstatus_in[7]) << 3) | 32'h0000_0080;
      win  = (exp_q.size() <= 1);
      tack = win & trap_req;
      mack = win & mret_req & ~trap_req;
      swr  = win & sw_valid & ~trap_req & ~mret_req;
      chk_out(tag, has, head[43:32], ed,
              {has && kind != 2'd0, has && kind == 2'd2, has && kind == 2'd3, tack, mack, swr},
              m_mmode);
      // Effect of the coming clock edge
      if (reset_in) begin
         exp_q.delete();
         m_mmode = 2'b00;
      end else begin
         if (has) void'(exp_q.pop_front());
         if (tack) begin
            exp_q.push_back({2'd1, 2'd0, 12'h341, trap_epc & ~32'h1});
            exp_q.push_back({2'd1, 2'd0, 12'h342, trap_cause});
            if (TVAL_EN) exp_q.push_back({2'd1, 2'd0, 12'h343, trap_tval});
            exp_q.push_back({2'd2, cur_mode, 12'h300, 32'h0});
         end else if (mack) begin
            exp_q.push_back({2'd3, 2'd0, 12'h300, 32'h0});
            m_mmode = mstatus_in[12:11];
         end else if (swr) begin
            exp_q.push_back({2'd0, 2'd0, sw_addr, sw_data});
         end
      end
   endtask

   // --------------------------------------------------------------- test body
   initial begin
      // ---------------- directed table
      //   rst swv swa     swd           trq epc           cause         tval          md   mrq mst
      //   e_wr e_addr e_data            flags     mmode
      add(1, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          0, 12'h000, 32'h0,        6'b000000, 2'd0);
      add(0, 1, 12'h305, 32'h8000_0100, 0, 32'h0,       32'h0,        32'h0,        2'd0, 0, 32'h8,
          0, 12'h000, 32'h0,        6'b000001, 2'd0);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h305, 32'h8000_0100, 6'b000000, 2'd0);
      // trap and software together: trap wins, software write is dropped
      add(0, 1, 12'h7C0, 32'h1111_1111, 1, 32'h0000_1003, 32'h0000_0002, 32'hDEAD_BEEF, 2'd3, 0, 32'h8,
          0, 12'h000, 32'h0,        6'b000100, 2'd0);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h341, 32'h0000_1002, 6'b100000, 2'd0);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h342, 32'h0000_0002, 6'b100000, 2'd0);
      if (TVAL_EN)
         add(0, 0, 12'h000, 32'h0,     0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
             1, 12'h343, 32'hDEAD_BEEF, 6'b100000, 2'd0);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h300, 32'h0000_1880, 6'b110000, 2'd0);
      // MRET from IDLE
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 1, 32'h1880,
          0, 12'h000, 32'h0,        6'b000010, 2'd0);
      // MRET write; a second MRET beats a software request in the same cycle
      add(0, 1, 12'h340, 32'hA,        0, 32'h0,        32'h0,        32'h0,        2'd0, 1, 32'h1880,
          1, 12'h300, 32'h0000_0088, 6'b101010, 2'd3);
      // back-to-back: software accepted in M_STATUS, mstatus taken live
      add(0, 1, 12'h340, 32'hA,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h1000,
          1, 12'h300, 32'h0000_0080, 6'b101001, 2'd3);
      add(0, 1, 12'h341, 32'hB,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h340, 32'h0000_000A, 6'b000001, 2'd3);
      // trap and MRET together: trap wins
      add(0, 0, 12'h000, 32'h0,        1, 32'h0000_2000, 32'h8000_000B, 32'h0,      2'd0, 1, 32'h8,
          1, 12'h341, 32'h0000_000B, 6'b000100, 2'd3);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h341, 32'h0000_2000, 6'b100000, 2'd3);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h342, 32'h8000_000B, 6'b100000, 2'd3);
      if (TVAL_EN)
         add(0, 0, 12'h000, 32'h0,     0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
             1, 12'h343, 32'h0,     6'b100000, 2'd3);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          1, 12'h300, 32'h0000_0080, 6'b110000, 2'd3);
      add(0, 0, 12'h000, 32'h0,        0, 32'h0,        32'h0,        32'h0,        2'd0, 0, 32'h8,
          0, 12'h000, 32'h0,        6'b000000, 2'd3);

      // ---------------- reset
      idle(32'h8);
      reset_in = 1'b1;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      #1;
      chk("reset state_dbg", 32'(state_dbg), 32'(IDLE));
      chk_out("reset", 1'b0, 12'h0, 32'h0, 6'b000000, 2'd0);
      chk("reset csr_wr_addr", 32'(csr_wr_addr), 32'h0);
      chk("reset csr_wr_data", csr_wr_data, 32'h0);

      // ---------------- table
      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk_in);
         drive(tbl[i].rst, tbl[i].swv, tbl[i].swa, tbl[i].swd, tbl[i].trq, tbl[i].epc,
               tbl[i].cause, tbl[i].tval, tbl[i].mode, tbl[i].mrq, tbl[i].mst);
         #1;
         chk_out($sformatf("vec%0d", i), tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_data,
                 tbl[i].e_flags, tbl[i].e_mmode);
      end

      // ---------------- reset in the middle of a trap
      @(negedge clk_in);
      drive(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, 32'h0000_4000, 32'h5, 32'h6, 2'd1, 1'b0, 32'h8);
      #1;
      chk("abort accept trap_ack", 32'(trap_ack), 32'h1);
      @(negedge clk_in);
      idle(32'h8);
      #1;
      chk("abort N+1 addr", 32'(csr_wr_addr), 32'h341);
      @(negedge clk_in);
      reset_in = 1'b1;
      #1;
      chk("abort N+2 addr", 32'(csr_wr_addr), 32'h342);
      @(negedge clk_in);
      reset_in = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("abort csr_wr", 32'(csr_wr), 32'h0);
         chk("abort trap_done", 32'(trap_done), 32'h0);
         chk("abort busy", 32'(busy), 32'h0);
         @(negedge clk_in);
      end
      drive(1'b0, 1'b1, 12'h123, 32'h55, 1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 32'h8);
      #1;
      chk("after abort sw_ready", 32'(sw_ready), 32'h1);
      @(negedge clk_in);
      idle(32'h8);
      #1;
      chk_out("after abort sw", 1'b1, 12'h123, 32'h55, 6'b000000, 2'd0);
      @(negedge clk_in);
      #1;
      chk("after abort idle csr_wr", 32'(csr_wr), 32'h0);

      // ---------------- randomized run against the model
      exp_q.delete();
      m_mmode = 2'b00;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_in);
         drive($urandom_range(0, 149) == 0,
               $urandom_range(0, 1) == 1, 12'($urandom), $urandom,
               $urandom_range(0, 7) == 0, $urandom, $urandom, $urandom,
               2'($urandom_range(0, 3)),
               $urandom_range(0, 5) == 0, $urandom);
         #1;
         model_cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
